// File: rtl/rtc_lectura_seq_pkg.sv
// rtc_pkg: shared definitions for the RTC bus sequencers.
//   - estado_t      : sequencer state encoding
//   - *_DEF         : default RTC register addresses
//   - ANCHO_FASE    : width of the bus phase counter
//   - es_bus()      : true for the four states that own the bus
package rtc_pkg;

    localparam int         ANCHO_FASE   = 8;
    localparam logic [7:0] DIR_SEG_DEF  = 8'h21;
    localparam logic [7:0] DIR_MIN_DEF  = 8'h22;
    localparam logic [7:0] DIR_HORA_DEF = 8'h23;
    localparam logic [1:0] ULTIMO_IDX   = 2'd2;   // hours is the last register read

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DIR_ACT  = 3'd1,
        DIR_LIB  = 3'd2,
        DATO_ACT = 3'd3,
        DATO_LIB = 3'd4,
        FIN      = 3'd5
    } estado_t;

    function automatic logic es_bus(input estado_t e);
        return (e == DIR_ACT) || (e == DIR_LIB) || (e == DATO_ACT) || (e == DATO_LIB);
    endfunction

endpackage

// File: rtl/rtc_lectura_seq_contador_fase.sv
// contador_fase: loadable down-counter that times one bus phase.
//   clk, reset  : clock, synchronous active-high reset
//   carga       : load 'valor' on this edge (takes priority over counting)
//   valor       : reload value (phase length minus one)
//   fin_cuenta  : terminal count, high while the count is zero
// The count saturates at zero so an un-reloaded counter stays terminal.
module contador_fase #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             carga,
    input  logic [ANCHO-1:0] valor,
    output logic             fin_cuenta
);

    logic [ANCHO-1:0] cuenta;

    always_ff @(posedge clk) begin
        if (reset)
            cuenta <= '0;
        else if (carga)
            cuenta <= valor;
        else if (cuenta != '0)
            cuenta <= cuenta - 1'b1;
    end

    assign fin_cuenta = (cuenta == '0);

endmodule

// File: rtl/rtc_lectura_seq.sv
// rtc_lectura_seq: reads seconds, minutes and hours from the RTC over a
// multiplexed address/data bus and latches them for the display path.
//   clk, reset          : 50 MHz clock, synchronous active-high reset
//   enable_leer         : level request; sampled only while idle
//   ad_in               : data returned by the RTC
//   cs_n, rd_n, wr_n    : active-low bus strobes (wr_n marks the address latch phase)
//   a_d                 : 0 = address phase, 1 = data phase
//   ad_out, ad_oe       : address and its tristate enable
//   dato_seg/min/hora   : last byte read from each register
//   listo               : one-cycle completion pulse
//   ocupado             : high while the bus sequence is running
// Every output is a flop written on the same edge the state changes, so
// the bus sees clean transitions between phases.
module rtc_lectura_seq
    import rtc_pkg::*;
#(
    parameter int         T_FASE   = 5,
    parameter logic [7:0] DIR_SEG  = DIR_SEG_DEF,
    parameter logic [7:0] DIR_MIN  = DIR_MIN_DEF,
    parameter logic [7:0] DIR_HORA = DIR_HORA_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_leer,
    input  logic [7:0] ad_in,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic [7:0] dato_seg,
    output logic [7:0] dato_min,
    output logic [7:0] dato_hora,
    output logic       listo,
    output logic       ocupado
);

    localparam logic [ANCHO_FASE-1:0] RECARGA = ANCHO_FASE'(T_FASE - 1);

    estado_t    estado;
    logic [1:0] indice;
    logic       fin_cuenta;
    logic       carga;

    function automatic logic [7:0] dir_de(input logic [1:0] i);
        case (i)
            2'd0:    return DIR_SEG;
            2'd1:    return DIR_MIN;
            default: return DIR_HORA;
        endcase
    endfunction

    // Keep the counter preloaded outside the bus states and reload it on the
    // last cycle of each phase, so every phase entry starts a full T_FASE.
    assign carga = !es_bus(estado) || fin_cuenta;

    contador_fase #(.ANCHO(ANCHO_FASE)) u_fase (
        .clk        (clk),
        .reset      (reset),
        .carga      (carga),
        .valor      (RECARGA),
        .fin_cuenta (fin_cuenta)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= IDLE;
            indice    <= 2'd0;
            cs_n      <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            a_d       <= 1'b1;
            ad_out    <= 8'h00;
            ad_oe     <= 1'b0;
            dato_seg  <= 8'h00;
            dato_min  <= 8'h00;
            dato_hora <= 8'h00;
            listo     <= 1'b0;
            ocupado   <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (enable_leer) begin
                        estado  <= DIR_ACT;
                        ocupado <= 1'b1;
                        cs_n    <= 1'b0;
                        wr_n    <= 1'b0;
                        a_d     <= 1'b0;
                        ad_oe   <= 1'b1;
                        ad_out  <= dir_de(indice);
                    end
                end
                DIR_ACT: begin
                    if (fin_cuenta) begin
                        estado <= DIR_LIB;
                        cs_n   <= 1'b1;
                        wr_n   <= 1'b1;
                    end
                end
                DIR_LIB: begin
                    if (fin_cuenta) begin
                        estado <= DATO_ACT;
                        cs_n   <= 1'b0;
                        rd_n   <= 1'b0;
                        a_d    <= 1'b1;
                        ad_oe  <= 1'b0;
                    end
                end
                DATO_ACT: begin
                    if (fin_cuenta) begin
                        estado <= DATO_LIB;
                        cs_n   <= 1'b1;
                        rd_n   <= 1'b1;
                        // Sample on the edge closing the read strobe window.
                        case (indice)
                            2'd0:    dato_seg  <= ad_in;
                            2'd1:    dato_min  <= ad_in;
                            default: dato_hora <= ad_in;
                        endcase
                    end
                end
                DATO_LIB: begin
                    if (fin_cuenta) begin
                        if (indice == ULTIMO_IDX) begin
                            estado  <= FIN;
                            indice  <= 2'd0;
                            ocupado <= 1'b0;
                            listo   <= 1'b1;
                        end else begin
                            estado  <= DIR_ACT;
                            indice  <= indice + 2'd1;
                            cs_n    <= 1'b0;
                            wr_n    <= 1'b0;
                            a_d     <= 1'b0;
                            ad_oe   <= 1'b1;
                            ad_out  <= dir_de(indice + 2'd1);
                        end
                    end
                end
                FIN: begin
                    estado <= IDLE;
                    listo  <= 1'b0;
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_lectura_seq.sv
// Bench for rtc_lectura_seq: directed table runs, hand sequences for polling
// and mid-sequence reset, and randomized traffic checked every cycle against
// a timeline model (elapsed busy cycles -> phase -> expected bus levels).
module tb_rtc_lectura_seq;

    localparam int TF   = 5;
    localparam int BUSY = 12 * TF;

    logic       clk = 1'b0;
    logic       reset, enable_leer;
    logic [7:0] ad_in;
    logic       cs_n, rd_n, wr_n, a_d, ad_oe, listo, ocupado;
    logic [7:0] ad_out, dato_seg, dato_min, dato_hora;

    always #10 clk = ~clk;

    rtc_lectura_seq #(.T_FASE(TF)) dut (
        .clk(clk), .reset(reset), .enable_leer(enable_leer), .ad_in(ad_in),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d), .ad_out(ad_out),
        .ad_oe(ad_oe), .dato_seg(dato_seg), .dato_min(dato_min),
        .dato_hora(dato_hora), .listo(listo), .ocupado(ocupado)
    );

    // RTC model: latches the address when wr_n rises, returns that register.
    logic [7:0] mem_seg, mem_min, mem_hora, lat;
    always @(posedge wr_n) lat <= ad_out;
    always_comb begin
        case (lat)
            8'h21:   ad_in = mem_seg;
            8'h22:   ad_in = mem_min;
            8'h23:   ad_in = mem_hora;
            default: ad_in = 8'hEE;
        endcase
    end

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference timeline: m_t counts busy cycles since the request was accepted.
    bit         m_act, m_listo;
    int         m_t;
    logic [7:0] m_seg, m_min, m_hora;

    always @(posedge clk) begin
        if (reset) begin
            m_act <= 0; m_t <= 0; m_listo <= 0;
            m_seg <= 0; m_min <= 0; m_hora <= 0;
        end else if (m_listo) begin
            m_listo <= 0;
        end else if (m_act) begin
            if ((m_t % TF) == TF - 1 && ((m_t / TF) % 4) == 2) begin
                case (m_t / (4 * TF))
                    0:       m_seg  <= ad_in;
                    1:       m_min  <= ad_in;
                    default: m_hora <= ad_in;
                endcase
            end
            if (m_t == BUSY - 1) begin
                m_act <= 0; m_listo <= 1;
            end else begin
                m_t <= m_t + 1;
            end
        end else if (enable_leer) begin
            m_act <= 1; m_t <= 0;
        end
    end

    logic [6:0] e_str;   // {cs_n, rd_n, wr_n, a_d, ad_oe, ocupado, listo}
    logic [7:0] e_adr;
    int         e_sub;

    always @(negedge clk) begin
        if (chk_on) begin
            if (!m_act) begin
                e_str = {5'b11110, 1'b0, m_listo};
            end else begin
                e_sub = (m_t / TF) % 4;
                e_adr = 8'h21 + 8'(m_t / (4 * TF));
                case (e_sub)
                    0:       e_str = 7'b0100110;
                    1:       e_str = 7'b1110110;
                    2:       e_str = 7'b0011010;
                    default: e_str = 7'b1111010;
                endcase
                if (e_sub < 2) chk("ad_out", ad_out, e_adr);
            end
            chk("strobes", {cs_n, rd_n, wr_n, a_d, ad_oe, ocupado, listo}, e_str);
            chk("datos", {dato_seg, dato_min, dato_hora}, {m_seg, m_min, m_hora});
        end
    end

    typedef struct {
        logic [7:0] seg, mnt, hor;
        int         en_len;      // cycles enable_leer stays high
        int         exp_listos;  // listo pulses expected in the window
        int         exp_pos;     // cycle of the listo pulse after the request edge
    } vec_t;

    vec_t tabla[4];

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!ocupado && !listo && !m_act && !m_listo) begin ok = 1; break; end
        end
        chk("drain_timeout", ok, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int         listos = 0, pos = -1, run = 0, oe_bad = 0, run_bad = 0;
        logic [7:0] adrs[$];
        bit         prev_dir = 0;
        mem_seg = v.seg; mem_min = v.mnt; mem_hora = v.hor;
        enable_leer = 1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (listo) begin listos++; pos = n; end
            if (!rd_n && ad_oe) oe_bad++;
            if (!cs_n && !wr_n && !prev_dir) adrs.push_back(ad_out);
            prev_dir = !cs_n && !wr_n;
            if (!cs_n) run++;
            else begin
                if (run != 0 && run != TF) run_bad++;
                run = 0;
            end
            if (n == v.en_len) enable_leer = 0;
        end
        chk("listo_count", listos, v.exp_listos);
        chk("listo_pos", pos, v.exp_pos);
        chk("dato_seg", dato_seg, v.seg);
        chk("dato_min", dato_min, v.mnt);
        chk("dato_hora", dato_hora, v.hor);
        chk("addr_count", adrs.size(), 3);
        if (adrs.size() == 3) begin
            chk("addr0", adrs[0], 8'h21);
            chk("addr1", adrs[1], 8'h22);
            chk("addr2", adrs[2], 8'h23);
        end
        chk("oe_during_rd", oe_bad, 0);
        chk("cs_low_len", run_bad, 0);
    endtask

    initial begin
        int         lq[$];
        int         busy_seen, listo_seen, len, rst_at;

        tabla[0] = '{seg: 8'h45, mnt: 8'h30, hor: 8'h12, en_len: 1,  exp_listos: 1, exp_pos: 61};
        tabla[1] = '{seg: 8'h00, mnt: 8'hFF, hor: 8'h59, en_len: 5,  exp_listos: 1, exp_pos: 61};
        tabla[2] = '{seg: 8'hA5, mnt: 8'h5A, hor: 8'h23, en_len: 33, exp_listos: 1, exp_pos: 61};
        tabla[3] = '{seg: 8'h59, mnt: 8'h01, hor: 8'h80, en_len: 61, exp_listos: 1, exp_pos: 61};

        reset = 1; enable_leer = 0;
        mem_seg = 8'h11; mem_min = 8'h22; mem_hora = 8'h33;
        repeat (2) @(negedge clk);
        chk_on = 1;
        chk("rst_ad_out", ad_out, 8'h00);
        chk("rst_outs", {cs_n, rd_n, wr_n, a_d, ad_oe, listo, ocupado}, 7'b1111000);
        chk("rst_datos", {dato_seg, dato_min, dato_hora}, 24'h0);

        // Idle with no request: nothing may move.
        reset = 0;
        busy_seen = 0; listo_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (ocupado || !cs_n) busy_seen++;
            if (listo) listo_seen++;
        end
        chk("idle_busy", busy_seen, 0);
        chk("idle_listo", listo_seen, 0);
        chk("idle_ad_out", ad_out, 8'h00);

        foreach (tabla[i]) run_vec(tabla[i]);

        // Continuous polling: enable held 200 cycles.
        mem_seg = 8'h07; mem_min = 8'h08; mem_hora = 8'h09;
        enable_leer = 1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (listo) begin
                lq.push_back(n);
                mem_seg = mem_seg + 8'h10;
                mem_min = mem_min + 8'h10;
                mem_hora = mem_hora + 8'h10;
            end
        end
        enable_leer = 0;
        chk("poll_count", lq.size(), 3);
        if (lq.size() == 3) begin
            chk("poll_listo1", lq[0], 61);
            chk("poll_listo2", lq[1], 123);
            chk("poll_listo3", lq[2], 185);
        end
        drain();
        chk("poll_data", {dato_seg, dato_min, dato_hora}, {mem_seg, mem_min, mem_hora});

        // Reset while the hours register is in its read strobe window.
        mem_seg = 8'h31; mem_min = 8'h32; mem_hora = 8'h33;
        enable_leer = 1;
        @(negedge clk);
        enable_leer = 0;
        repeat (51) @(negedge clk);
        chk("pre_rst_in_hora_rd", {cs_n, rd_n, a_d}, 3'b001);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("midrst_strobes", {cs_n, rd_n, ad_oe, listo, ocupado}, 5'b11000);
        chk("midrst_datos", {dato_seg, dato_min, dato_hora}, 24'h0);
        listo_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (listo || ocupado) listo_seen++;
        end
        chk("midrst_quiet", listo_seen, 0);
        run_vec(tabla[0]);

        // Randomized traffic; the per-cycle model does the checking.
        for (int it = 0; it < 40; it++) begin
            mem_seg = 8'($urandom); mem_min = 8'($urandom); mem_hora = 8'($urandom);
            len    = int'($urandom_range(1, 150));
            rst_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 70)) : -1;
            enable_leer = 1;
            for (int n = 1; n <= len; n++) begin
                @(negedge clk);
                reset = (n == rst_at);
                enable_leer = (n < len);
                if ($urandom_range(0, 7) == 0) mem_min = 8'($urandom);
            end
            reset = 0; enable_leer = 0;
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
